seq_shift_add_multiplier: RTL and testbench

Sequential unsigned shift-add multiplier. It is the inverse of the restoring divider and consumes the same operand widths: an N-bit multiplicand times an N-bit multiplier gives a 2N-bit product. The block scans the multiplier LSB-first and shifts a combined accumulator right, which is the mirror of the divider's left-shifting datapath. It sits beside the divider in the arithmetic unit and uses the same start/done handshake.

---
 rtl/arith_pkg.sv | 12 +
 rtl/shift_register_right.sv | 28 ++
 rtl/seq_shift_add_multiplier.sv | 117 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: controller state encoding and default operand width.
package arith_pkg;

    localparam int MUL_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_register_right.sv
// Parameterised right-shift register with parallel load (load wins over shift).
module shift_register_right #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             ld,
    input  logic             shr,
    input  logic [WIDTH-1:0] PI,
    output logic [WIDTH-1:0] PO
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (ld) begin
            data_q <= PI;
        end else if (shr) begin
            data_q <= {sin, data_q[WIDTH-1:1]};
        end
    end

    assign PO = data_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: N x N -> 2N product, one multiplier bit per cycle.
//   state | meaning
//   IDLE  | waiting for start, P held
//   CALC  | one add/shift iteration per edge, N iterations
//   DONE  | P valid, done pulses for one cycle
module seq_shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int N = MUL_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int AW = 2*N + 1;
    localparam int CW = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_pi;
    logic [AW-1:0]    acc_shifted;
    logic             acc_ld;
    logic             acc_shr;
    logic [N:0]       sum;

    // ACC = {carry, H, L}; the add is N+1 bits wide so the carry lands in H's MSB after the shift.
    always_comb begin
        sum = {1'b0, acc[2*N-1:N]};
        if (acc[0]) begin
            sum = {acc[AW-1], acc[2*N-1:N]} + {1'b0, m_q};
        end
    end

    assign acc_shifted = {1'b0, sum, acc[N-1:1]};

    // Without an add the iteration is a plain logical shift, so the register shifts in place.
    shift_register_right #(
        .WIDTH (AW)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .sin (1'b0),
        .ld  (acc_ld),
        .shr (acc_shr),
        .PI  (acc_pi),
        .PO  (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        acc_ld  = 1'b0;
        acc_shr = 1'b0;
        acc_pi  = acc_shifted;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_ld  = 1'b1;
                    acc_pi  = {1'b0, {N{1'b0}}, B};
                    m_d     = A;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (acc[0]) begin
                    acc_ld = 1'b1;
                end else begin
                    acc_shr = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    p_d     = acc_shifted[2*N-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign P    = p_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier with an expected-product queue.
module tb_seq_shift_add_multiplier;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] P;
    logic           busy;
    logic           done;

    int checks = 0;
    int passed = 0;
    logic [2*N-1:0] exp_q[$];

    seq_shift_add_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] wa;
        logic [2*N-1:0] wb;
        wa = {{N{1'b0}}, a};
        wb = {{N{1'b0}}, b};
        return wa * wb;
    endfunction

    // Called at the first negedge after the accepting edge; samples until done (bounded).
    task automatic wait_done(output int lat, output int busy_cycles, output int p_changes, output bit got);
        logic [2*N-1:0] p0;
        p0 = P;
        lat = 0;
        busy_cycles = 0;
        p_changes = 0;
        got = 1'b0;
        for (int i = 0; i < 4*N && !got; i++) begin
            lat++;
            if (busy) busy_cycles++;
            if (done) got = 1'b1;
            else begin
                if (P !== p0) p_changes++;
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_op(input string tag);
        int lat, bc, pc;
        bit got;
        logic [2*N-1:0] e;
        wait_done(lat, bc, pc, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(N + 1));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(N));
        check({tag, "_p_stable"}, 32'(pc), 32'd0);
        check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_product"}, 32'(P), 32'(e));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_p_held"}, 32'(P), 32'(e));
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        finish_op(tag);
    endtask

    initial begin
        int dcount, bcount;
        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("reset_p", 32'(P), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(5'd5, 5'd17, "a5_b17");
        do_op(5'd31, 5'd31, "max");
        do_op(5'd0, 5'd23, "a0");
        do_op(5'd1, 5'd31, "a1_b31");
        do_op(5'd23, 5'd0, "b0");
        do_op(5'd19, 5'd26, "a19_b26");

        // start held high; operands changed mid-CALC must not affect the running product
        @(negedge clk);
        A = 5'd3;
        B = 5'd7;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(5'd3, 5'd7));
        @(negedge clk);
        A = 5'd9;
        B = 5'd9;
        begin
            int lat, bc, pc;
            bit got;
            logic [2*N-1:0] e;
            wait_done(lat, bc, pc, got);
            check("held_done_seen", 32'(got), 32'd1);
            check("held_latency", 32'(lat), 32'(N + 1));
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("held_product", 32'(P), 32'(e));
        end
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        exp_q.push_back(model(5'd9, 5'd9));
        @(negedge clk);
        start = 1'b0;
        check("held_reaccept_busy", 32'(busy), 32'd1);
        finish_op("held_second");

        // asynchronous reset in the third CALC cycle
        @(negedge clk);
        A = 5'd13;
        B = 5'd11;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(5'd13, 5'd11));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_p", 32'(P), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        bcount = 0;
        for (int i = 0; i < 2*N; i++) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_stays_idle", 32'(bcount), 32'd0);
        check("abort_p_zero", 32'(P), 32'd0);

        do_op(5'd6, 5'd4, "post_reset");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
